// File: rtl/filter_frame_ctrl.sv
// filter_frame_ctrl
// Frame-level sequencer for the 3x3 window memory and the edge-preserving
// filter datapath. A start request streams every window of one frame out of
// the memory (rd). The write strobe (wr) opens when the first filtered pixel
// leaves the filter pipeline. The block then waits for the memory's
// write-complete pulse, with a timeout.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle frame start request (honoured only in IDLE)
//   abort        synchronous abort, any state, wins over start
//   mem_done     write-complete pulse from the window memory
//   rd / wr      memory read / write strobes
//   busy         high in every state except IDLE
//   frame_done   one-cycle pulse on a successful frame end
//   err          sticky timeout flag, cleared by the next start
//   rd_cnt       windows issued this frame (saturates at IMG_W*IMG_H)
//   wr_cnt       filtered pixels written this frame
//   frame_count  completed frames; a real counter only with FRAME_CNT_EN
//
// Build option: define FRAME_CNT_EN to build the wrapping 16-bit frame
// counter. Without it, frame_count is tied to zero.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start; strobes low
// RUN       | read burst and/or write burst in progress
// WAIT_DONE | both bursts over; waiting for mem_done or timeout
// FINISH    | frame_done pulse, back to IDLE next cycle

module filter_frame_ctrl #(
   parameter int IMG_W    = 128,
   parameter int IMG_H    = 128,
   parameter int WR_W     = 126,
   parameter int WR_H     = 126,
   parameter int FILT_LAT = 3,
   parameter int TIMEOUT  = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        mem_done,
   output logic        rd,
   output logic        wr,
   output logic        busy,
   output logic        frame_done,
   output logic        err,
   output logic [14:0] rd_cnt,
   output logic [14:0] wr_cnt,
   output logic [15:0] frame_count
);

   localparam int RD_LEN = IMG_W * IMG_H;
   localparam int WR_LEN = WR_W * WR_H;
   localparam int LAT_W  = $clog2(FILT_LAT + 1);
   localparam int TO_W   = ($clog2(TIMEOUT) < 10) ? 10 : $clog2(TIMEOUT);

   localparam logic [14:0]       RD_LEN_C  = 15'(RD_LEN);
   localparam logic [14:0]       WR_LAST_C = 15'(WR_LEN - 1);
   localparam logic [LAT_W-1:0]  LAT_C     = LAT_W'(FILT_LAT);
   localparam logic [TO_W-1:0]   TO_LAST_C = TO_W'(TIMEOUT - 1);

   generate
      if (FILT_LAT < 1 || WR_LEN < 1 || WR_LEN > RD_LEN || RD_LEN > 32767
          || TIMEOUT < 1) begin : g_bad_cfg
         $error("filter_frame_ctrl: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RUN       = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_FINISH    = 2'd3
   } state_t;

   state_t            state_q, state_nx;
   logic              rd_q, rd_nx;
   logic              wr_q, wr_nx;
   logic              busy_q;
   logic              fdone_q, fdone_nx;
   logic              err_q, err_nx;
   logic [14:0]       rd_cnt_q, rd_cnt_nx;
   logic [14:0]       wr_cnt_q, wr_cnt_nx;
   // rd_tmr counts the read cycles still to go after the current one; it holds
   // RD_LEN only in the first rd cycle, which carries no window yet.
   logic [14:0]       rd_tmr_q, rd_tmr_nx;
   logic [14:0]       wr_tmr_q, wr_tmr_nx;
   logic [LAT_W-1:0]  lat_tmr_q, lat_tmr_nx;
   logic              wr_pend_q, wr_pend_nx;
   logic              done_seen_q, done_seen_nx;
   logic [TO_W-1:0]   to_tmr_q, to_tmr_nx;

   always_comb begin
      state_nx     = state_q;
      rd_nx        = rd_q;
      wr_nx        = wr_q;
      fdone_nx     = 1'b0;
      err_nx       = err_q;
      rd_cnt_nx    = rd_cnt_q;
      wr_cnt_nx    = wr_cnt_q;
      rd_tmr_nx    = rd_tmr_q;
      wr_tmr_nx    = wr_tmr_q;
      lat_tmr_nx   = lat_tmr_q;
      wr_pend_nx   = wr_pend_q;
      done_seen_nx = done_seen_q;
      to_tmr_nx    = to_tmr_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_nx     = S_RUN;
               rd_nx        = 1'b1;
               rd_tmr_nx    = RD_LEN_C;
               rd_cnt_nx    = '0;
               wr_cnt_nx    = '0;
               err_nx       = 1'b0;
               lat_tmr_nx   = LAT_C;
               wr_pend_nx   = 1'b1;
               done_seen_nx = 1'b0;
            end
         end

         S_RUN: begin
            // An early write-complete is remembered for WAIT_DONE.
            if (mem_done) done_seen_nx = 1'b1;

            if (rd_q) begin
               if (rd_tmr_q != RD_LEN_C && rd_cnt_q != RD_LEN_C)
                  rd_cnt_nx = rd_cnt_q + 15'd1;
               if (rd_tmr_q == '0) rd_nx = 1'b0;
               else                rd_tmr_nx = rd_tmr_q - 15'd1;
            end

            // The latency timer expires in the cycle before the first filtered
            // pixel, so wr rises exactly FILT_LAT cycles after the first window.
            if (wr_pend_q) begin
               if (lat_tmr_q == '0) begin
                  wr_pend_nx = 1'b0;
                  wr_nx      = 1'b1;
                  wr_tmr_nx  = WR_LAST_C;
               end else begin
                  lat_tmr_nx = lat_tmr_q - LAT_W'(1);
               end
            end else if (wr_q) begin
               wr_cnt_nx = wr_cnt_q + 15'd1;
               if (wr_tmr_q == '0) wr_nx = 1'b0;
               else                wr_tmr_nx = wr_tmr_q - 15'd1;
            end

            if (!rd_nx && !wr_nx && !wr_pend_nx) begin
               state_nx  = S_WAIT_DONE;
               to_tmr_nx = TO_LAST_C;
            end
         end

         S_WAIT_DONE: begin
            if (mem_done || done_seen_q) begin
               state_nx = S_FINISH;
               fdone_nx = 1'b1;
            end else if (to_tmr_q == '0) begin
               state_nx = S_IDLE;
               err_nx   = 1'b1;
            end else begin
               to_tmr_nx = to_tmr_q - TO_W'(1);
            end
         end

         S_FINISH: state_nx = S_IDLE;

         default: state_nx = S_IDLE;
      endcase

      // Abort freezes the visible counters and error flag where they stand.
      if (abort) begin
         state_nx  = S_IDLE;
         rd_nx     = 1'b0;
         wr_nx     = 1'b0;
         fdone_nx  = 1'b0;
         err_nx    = err_q;
         rd_cnt_nx = rd_cnt_q;
         wr_cnt_nx = wr_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         busy_q      <= 1'b0;
         fdone_q     <= 1'b0;
         err_q       <= 1'b0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         rd_tmr_q    <= '0;
         wr_tmr_q    <= '0;
         lat_tmr_q   <= '0;
         wr_pend_q   <= 1'b0;
         done_seen_q <= 1'b0;
         to_tmr_q    <= '0;
      end else begin
         state_q     <= state_nx;
         rd_q        <= rd_nx;
         wr_q        <= wr_nx;
         busy_q      <= (state_nx != S_IDLE);
         fdone_q     <= fdone_nx;
         err_q       <= err_nx;
         rd_cnt_q    <= rd_cnt_nx;
         wr_cnt_q    <= wr_cnt_nx;
         rd_tmr_q    <= rd_tmr_nx;
         wr_tmr_q    <= wr_tmr_nx;
         lat_tmr_q   <= lat_tmr_nx;
         wr_pend_q   <= wr_pend_nx;
         done_seen_q <= done_seen_nx;
         to_tmr_q    <= to_tmr_nx;
      end
   end

`ifdef FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        frame_cnt_q <= '0;
      else if (fdone_nx) frame_cnt_q <= frame_cnt_q + 16'd1;
   end

   assign frame_count = frame_cnt_q;
`else
   assign frame_count = 16'd0;
`endif

   assign rd         = rd_q;
   assign wr         = wr_q;
   assign busy       = busy_q;
   assign frame_done = fdone_q;
   assign err        = err_q;
   assign rd_cnt     = rd_cnt_q;
   assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Testbench for filter_frame_ctrl with a 4x4 read frame, a 2x2 write frame,
// FILT_LAT=3 and TIMEOUT=8.
module tb_filter_frame_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        mem_done;
   logic        rd;
   logic        wr;
   logic        busy;
   logic        frame_done;
   logic        err;
   logic [14:0] rd_cnt;
   logic [14:0] wr_cnt;
   logic [15:0] frame_count;

   int n_cmp = 0;
   int n_bad = 0;
   int fd_pulses = 0;

   filter_frame_ctrl #(
      .IMG_W(4), .IMG_H(4), .WR_W(2), .WR_H(2), .FILT_LAT(3), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .mem_done(mem_done), .rd(rd), .wr(wr), .busy(busy),
      .frame_done(frame_done), .err(err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
      .frame_count(frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done) fd_pulses++;

   typedef struct {
      int start, abort, mem_done;
      int rd, wr, busy, fd, err, rd_cnt, wr_cnt;
   } vec_t;

   vec_t tbl[20];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Start one frame, pulse mem_done while still in RUN, and wait for the
   // frame_done pulse under a cycle budget.
   task automatic run_frame(input string nm);
      bit seen;
      start = 1'b1;
      step();
      start = 1'b0;
      adv(9);
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (frame_done) seen = 1'b1;
      end
      chk({nm, "_frame_done_seen"}, int'(seen), 1);
      step();
      chk({nm, "_busy_after"}, int'(busy), 0);
      chk({nm, "_rd_cnt"}, int'(rd_cnt), 16);
      chk({nm, "_wr_cnt"}, int'(wr_cnt), 4);
   endtask

   initial begin
      int fd0;
      int exp_fc;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mem_done = 1'b0;

      //            st ab md  rd wr by fd er rc wc
      tbl[0]  = '{1, 0, 0,  1, 0, 1, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0,  1, 0, 1, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 0,  1, 0, 1, 0, 0, 1, 0};
      tbl[3]  = '{0, 0, 0,  1, 0, 1, 0, 0, 2, 0};
      tbl[4]  = '{0, 0, 0,  1, 1, 1, 0, 0, 3, 0};
      tbl[5]  = '{0, 0, 0,  1, 1, 1, 0, 0, 4, 1};
      tbl[6]  = '{0, 0, 0,  1, 1, 1, 0, 0, 5, 2};
      tbl[7]  = '{0, 0, 0,  1, 1, 1, 0, 0, 6, 3};
      tbl[8]  = '{0, 0, 0,  1, 0, 1, 0, 0, 7, 4};
      tbl[9]  = '{0, 0, 0,  1, 0, 1, 0, 0, 8, 4};
      tbl[10] = '{0, 0, 1,  1, 0, 1, 0, 0, 9, 4};
      tbl[11] = '{0, 0, 0,  1, 0, 1, 0, 0, 10, 4};
      tbl[12] = '{0, 0, 0,  1, 0, 1, 0, 0, 11, 4};
      tbl[13] = '{0, 0, 0,  1, 0, 1, 0, 0, 12, 4};
      tbl[14] = '{0, 0, 0,  1, 0, 1, 0, 0, 13, 4};
      tbl[15] = '{0, 0, 0,  1, 0, 1, 0, 0, 14, 4};
      tbl[16] = '{0, 0, 0,  1, 0, 1, 0, 0, 15, 4};
      tbl[17] = '{0, 0, 0,  0, 0, 1, 0, 0, 16, 4};
      tbl[18] = '{0, 0, 0,  0, 0, 1, 1, 0, 16, 4};
      tbl[19] = '{0, 0, 0,  0, 0, 0, 0, 0, 16, 4};

      // Reset values
      #12;
      chk("rst_rd", int'(rd), 0);
      chk("rst_wr", int'(wr), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_rd_cnt", int'(rd_cnt), 0);
      chk("rst_frame_count", int'(frame_count), 0);
      #5 rst_n = 1'b1;

      // Reset in the middle of a frame clears everything at once
      start = 1'b1;
      step();
      start = 1'b0;
      adv(6);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rd", int'(rd), 0);
      chk("midrst_wr", int'(wr), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_rd_cnt", int'(rd_cnt), 0);
      chk("midrst_wr_cnt", int'(wr_cnt), 0);
      #3 rst_n = 1'b1;
      step();

      // Nominal frame, mem_done arriving during RUN and latched
      for (int i = 0; i < 20; i++) begin
         start    = tbl[i].start[0];
         abort    = tbl[i].abort[0];
         mem_done = tbl[i].mem_done[0];
         step();
         if (int'(rd) != tbl[i].rd || int'(wr) != tbl[i].wr
             || int'(busy) != tbl[i].busy || int'(frame_done) != tbl[i].fd
             || int'(err) != tbl[i].err || int'(rd_cnt) != tbl[i].rd_cnt
             || int'(wr_cnt) != tbl[i].wr_cnt) begin
            n_bad++;
            $display("FAIL vec%0d: got rd=%0d wr=%0d busy=%0d fd=%0d err=%0d rc=%0d wc=%0d expected rd=%0d wr=%0d busy=%0d fd=%0d err=%0d rc=%0d wc=%0d",
                     i, rd, wr, busy, frame_done, err, rd_cnt, wr_cnt,
                     tbl[i].rd, tbl[i].wr, tbl[i].busy, tbl[i].fd,
                     tbl[i].err, tbl[i].rd_cnt, tbl[i].wr_cnt);
         end
         n_cmp++;
      end
      start = 1'b0; mem_done = 1'b0;
      step();

      // Timeout: WAIT_DONE entered at t0+17, err rises at t0+25
      fd0 = fd_pulses;
      start = 1'b1;
      step();
      start = 1'b0;
      adv(24);
      chk("to_err_before", int'(err), 0);
      chk("to_busy_before", int'(busy), 1);
      step();
      chk("to_err_set", int'(err), 1);
      chk("to_busy_idle", int'(busy), 0);
      adv(3);
      chk("to_no_frame_done", fd_pulses, fd0);
      chk("to_err_sticky", int'(err), 1);

      // Next start clears err; mem_done given in WAIT_DONE itself
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_err_clear", int'(err), 0);
      adv(17);
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      chk("wait_md_frame_done", int'(frame_done), 1);
      step();
      chk("wait_md_busy", int'(busy), 0);
      chk("wait_md_err", int'(err), 0);

      // Abort at t0+5
      fd0 = fd_pulses;
      start = 1'b1;
      step();
      start = 1'b0;
      adv(5);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_rd", int'(rd), 0);
      chk("abort_wr", int'(wr), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_rd_cnt_hold", int'(rd_cnt), 4);
      chk("abort_wr_cnt_hold", int'(wr_cnt), 1);
      adv(30);
      chk("abort_no_frame_done", fd_pulses, fd0);
      chk("abort_still_idle", int'(busy), 0);
      run_frame("abort_restart");

      // start held high through RUN starts nothing extra
      fd0 = fd_pulses;
      start = 1'b1;
      step();
      adv(16);
      start = 1'b0;
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      step();
      chk("held_frame_done", int'(frame_done), 1);
      step();
      chk("held_busy_drop", int'(busy), 0);
      adv(5);
      chk("held_one_frame", fd_pulses, fd0 + 1);
      chk("held_no_restart", int'(busy), 0);

      // start and abort together in IDLE: abort wins
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", int'(busy), 0);
      chk("sa_rd", int'(rd), 0);
      adv(3);
      chk("sa_rd_cnt_kept", int'(rd_cnt), 16);

      // Three back-to-back frames plus one aborted frame
      run_frame("b2b0");
      run_frame("b2b1");
      run_frame("b2b2");
      start = 1'b1;
      step();
      start = 1'b0;
      adv(3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      adv(2);
      // Completed frames: nominal, post-timeout restart, post-abort restart,
      // held-start frame, and three back-to-back frames.
      chk("fd_pulse_total", fd_pulses, 7);
`ifdef FRAME_CNT_EN
      exp_fc = 7;
`else
      exp_fc = 0;
`endif
      chk("frame_count", int'(frame_count), exp_fc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
